// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes, memory-wait freeze.
// Define HAZARD_PERF_CNT_EN to build the stall_cnt performance counter (otherwise stall_cnt reads 0).
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [4:0]  ZERO_REG    = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  input  logic        mem_access,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        mem_err,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       memstall, loaduse, freeze, decode;

  assign memstall = mem_access & ~dmem_ready;
  assign loaduse  = ex_memread & (ex_rd != ZERO_REG) &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= (state_nxt == ERR);
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    freeze       = 1'b0;
    decode       = 1'b0;
    case (state)
      RUN: begin
        if (memstall) begin
          freeze       = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          decode = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          freeze = 1'b1;
          if (wait_cnt == TIMEOUT) state_nxt = ERR;
          else wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          decode       = 1'b1;
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end
      end
      ERR: freeze = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  // A frozen pipeline still clocks a bubble into MEM/WB so the stuck MEM op never writes back twice.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      if (freeze) begin
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
      end else if (decode) begin
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        if (ex_branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (loaduse) begin
          idex_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 32'd0;
    else if (!pc_en) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, hand sequences for multi-cycle cases, random run vs model.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, mem_err}
  localparam logic [8:0] ALL_EN  = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] FROZEN  = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] ERRST   = 9'b0_0_0_0_0_0_1_1_1;
  localparam logic [8:0] BRANCH  = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] LOADUSE = 9'b0_0_0_1_1_1_1_0_0;
  localparam logic [8:0] NONE    = 9'b0;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic uses2, memread, br, macc, rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_uses_rs2 = 0, ex_memread = 0, ex_branch_taken = 0, mem_access = 0, dmem_ready = 0;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, mem_err;
  logic [31:0] stall_cnt;
  logic [8:0] outs;

  int errors = 0, checks = 0;
  int m_wait = 0;
  bit m_err = 0;
  int unsigned m_stalls = 0;
  vec_t tbl[$];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .ZERO_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush, mem_err};

  always #5 clk = ~clk;

  function automatic logic [31:0] stall_exp(input int unsigned n);
`ifdef HAZARD_PERF_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic [4:0] rs1, rs2, input logic uses2, input logic [4:0] rd,
                             input logic memread, br, macc, rdy);
    in_t i;
    i.rs1 = rs1; i.rs2 = rs2; i.uses2 = uses2; i.rd = rd;
    i.memread = memread; i.br = br; i.macc = macc; i.rdy = rdy;
    return i;
  endfunction

  task automatic drive(input in_t i);
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs2 = i.uses2; ex_rd = i.rd;
    ex_memread = i.memread; ex_branch_taken = i.br; mem_access = i.macc; dmem_ready = i.rdy;
  endtask

  // Reference: a stall episode is a run of consecutive frozen cycles; the (TO+1)th one times out.
  task automatic model_step(input in_t i, output logic [8:0] e);
    bit lu;
    lu = i.memread && i.rd != 5'd31 && (i.rd == i.rs1 || (i.uses2 && i.rd == i.rs2));
    if (m_err) e = ERRST;
    else if ((m_wait > 0 && !i.rdy) || (m_wait == 0 && i.macc && !i.rdy)) begin
      e = FROZEN;
      if (m_wait == TO) m_err = 1;
      else m_wait++;
    end else begin
      m_wait = 0;
      e = i.br ? BRANCH : (lu ? LOADUSE : ALL_EN);
    end
    if (!e[8]) m_stalls++;
  endtask

  // One clock cycle: inputs after the edge, outputs sampled on the falling edge.
  task automatic cycle(input string nm, input in_t i, input bit use_const, input logic [8:0] cexp);
    logic [8:0] e;
    int unsigned s;
    drive(i);
    s = m_stalls;
    model_step(i, e);
    @(negedge clk);
    check({nm, "_outs"}, {23'd0, outs}, {23'd0, use_const ? cexp : e});
    if (!use_const) check({nm, "_stall_cnt"}, stall_cnt, stall_exp(s));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    m_wait = 0; m_err = 0; m_stalls = 0;
    @(negedge clk);
    check("reset_outs", {23'd0, outs}, {23'd0, NONE});
    check("reset_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic add_vec(input string nm, input in_t i, input logic [8:0] exp);
    vec_t v;
    v.name = nm; v.in = i; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    //                    rs1 rs2 u2  rd mrd br macc rdy
    add_vec("no_hazard",  mk(1,  2, 1,  3, 1, 0, 0, 0), ALL_EN);
    add_vec("lu_rs1",     mk(5,  2, 0,  5, 1, 0, 0, 0), LOADUSE);
    add_vec("xzr_rs1",    mk(31, 2, 1, 31, 1, 0, 0, 0), ALL_EN);
    add_vec("rs2_unused", mk(1,  7, 0,  7, 1, 0, 0, 0), ALL_EN);
    add_vec("rs2_used",   mk(1,  7, 1,  7, 1, 0, 0, 0), LOADUSE);
    add_vec("not_load",   mk(5,  5, 1,  5, 0, 0, 0, 0), ALL_EN);
    add_vec("br_over_lu", mk(5,  2, 0,  5, 1, 1, 0, 0), BRANCH);
    add_vec("branch",     mk(1,  2, 0,  3, 0, 1, 0, 1), BRANCH);
    add_vec("mem_ready",  mk(5,  2, 0,  5, 1, 0, 1, 1), LOADUSE);
    add_vec("memstall",   mk(5,  2, 0,  5, 1, 1, 1, 0), FROZEN);

    foreach (tbl[k]) begin
      do_reset();
      cycle(tbl[k].name, tbl[k].in, 1, tbl[k].exp);
    end

    // Load-use bubble lasts exactly one cycle.
    do_reset();
    cycle("lu_seq_c1", mk(5, 0, 0, 5, 1, 0, 0, 0), 1, LOADUSE);
    cycle("lu_seq_c2", mk(5, 0, 0, 5, 0, 0, 0, 0), 1, ALL_EN);

    // Three-cycle memory wait, then release.
    do_reset();
    for (int c = 0; c < 3; c++) cycle("memwait_frz", mk(0, 0, 0, 0, 0, 0, 1, 0), 1, FROZEN);
    drive(mk(0, 0, 0, 0, 0, 0, 1, 1));
    @(negedge clk);
    check("memwait_release", {23'd0, outs}, {23'd0, ALL_EN});
    check("memwait_stall_cnt", stall_cnt, stall_exp(3));
    @(posedge clk); #1;
    cycle("memwait_after", mk(0, 0, 0, 0, 0, 0, 0, 1), 1, ALL_EN);

    // Timeout: fifth frozen cycle errors; sticky until async reset.
    do_reset();
    for (int c = 0; c < TO + 1; c++) cycle("to_frz", mk(0, 0, 0, 0, 0, 0, 1, 0), 1, FROZEN);
    cycle("to_err1", mk(0, 0, 0, 0, 0, 0, 0, 1), 1, ERRST);
    cycle("to_err2", mk(0, 0, 0, 0, 0, 1, 1, 1), 1, ERRST);
    check("to_stall_cnt", stall_cnt, stall_exp(TO + 3));
    #2 rst = 0;
    #1;
    check("async_rst_outs", {23'd0, outs}, {23'd0, NONE});
    check("async_rst_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1;
    m_wait = 0; m_err = 0; m_stalls = 0;
    @(posedge clk); #1;
    cycle("post_err_run", mk(0, 0, 0, 0, 0, 0, 0, 0), 1, ALL_EN);

    // Branch frozen in EX during a memory wait is honoured only on release.
    do_reset();
    cycle("wb_frz1", mk(0, 0, 0, 0, 0, 1, 1, 0), 1, FROZEN);
    cycle("wb_frz2", mk(0, 0, 0, 0, 0, 1, 1, 0), 1, FROZEN);
    cycle("wb_release", mk(0, 0, 0, 0, 0, 1, 1, 1), 1, BRANCH);
    cycle("wb_after", mk(0, 0, 0, 0, 0, 0, 0, 0), 1, ALL_EN);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      in_t r;
      logic [4:0] pick[4];
      if (n % 75 == 74) do_reset();
      pick[0] = 5'd5; pick[1] = 5'd7; pick[2] = 5'd31; pick[3] = 5'($urandom_range(0, 31));
      r.rs1 = pick[$urandom_range(0, 3)];
      r.rs2 = pick[$urandom_range(0, 3)];
      r.rd = pick[$urandom_range(0, 3)];
      r.uses2 = 1'($urandom_range(0, 1));
      r.memread = 1'($urandom_range(0, 1));
      r.br = ($urandom_range(0, 4) == 0);
      r.macc = ($urandom_range(0, 2) == 0);
      r.rdy = ($urandom_range(0, 4) != 0);
      cycle("rand", r, 0, NONE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage 64-bit pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three hazard classes:
  - load-use hazards, by inserting a 1-cycle bubble;
  - taken branches, by flushing the 2 younger stages;
  - multi-cycle data-memory accesses, by freezing the pipeline with a timeout.
- Includes a sticky error halt on timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before error halt. Legal range 2..255.
- ZERO_REG, 31: register index that is never a hazard source/destination (XZR).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage destination register
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved taken branch
- mem_access  in  1  MEM instruction is a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC write enable
- ifid_en  out  1  IF/ID enable
- ifid_flush  out  1  IF/ID load bubble
- idex_en  out  1  ID/EX enable
- idex_flush  out  1  ID/EX load bubble
- exmem_en  out  1  EX/MEM enable
- memwb_en  out  1  MEM/WB enable
- memwb_flush  out  1  MEM/WB load bubble (WB=0)
- mem_err  out  1  sticky timeout error
- stall_cnt  out  32  cycles with pc_en=0 (optional, see below)

Behaviour:
- States: RUN, MEM_WAIT, ERR. State register plus 8-bit wait_cnt, both async-cleared by rst=0.
- Outputs are Mealy: combinational from state and current inputs.
- While rst=0: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, all *_en=0, all *_flush=0.
- First cycle after rst release: normal RUN decode.
- Hazard conditions:
  - memstall = mem_access & !dmem_ready
  - loaduse = ex_memread & ex_rd!=ZERO_REG & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2))
- RUN priority, highest first:
  1. memstall: all *_en=0 and memwb_flush=1 (memwb_en=1 so the bubble loads, no duplicate WB). Next state MEM_WAIT, wait_cnt=1.
  2. ex_branch_taken: all *_en=1, ifid_flush=1, idex_flush=1. Load-use is ignored because the ID instruction is squashed.
  3. loaduse: pc_en=0, ifid_en=0, idex_flush=1 (idex_en=1), exmem_en=1, memwb_en=1.
  4. Otherwise: all *_en=1, no flush.
- MEM_WAIT:
  - dmem_ready=0 and wait_cnt<MEM_TIMEOUT: same outputs as RUN/memstall; wait_cnt+1.
  - dmem_ready=0 and wait_cnt==MEM_TIMEOUT: go to ERR, all *_en=0, mem_err<=1.
  - dmem_ready=1: go to RUN, wait_cnt=0. Outputs this cycle follow RUN priorities 2..4 on current inputs (a branch frozen in EX is honoured on the advancing edge).
- ERR: all *_en=0, memwb_flush=1, mem_err=1. Exits only via rst.
- Reset asserted mid-MEM_WAIT or in ERR: immediate return to reset values.
- Flushes are only asserted when the corresponding stage register is enabled.
- Never assert flush and en=0 on the same register.
- No combinational path from any output back to any input.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments by 1 on every rising clk with rst=1 and pc_en=0. It wraps 0xFFFFFFFF to 0.
- Undefined: stall_cnt is tied to 32'd0 and no counter flops are inferred.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, mem_access=0 -> exactly 1 cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle (ex_memread=0) all en=1.
- XZR / rs2 masking:
  - ex_rd=31=id_rs1 with ex_memread=1 -> no stall.
  - ex_rd=7=id_rs2 with id_uses_rs2=0 -> no stall.
  - Same with id_uses_rs2=1 -> stall.
- Branch beats load-use: ex_branch_taken=1 with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1 for 1 cycle.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 ->
  - 3 cycles all en=0 and memwb_flush=1, state MEM_WAIT;
  - 4th cycle all en=1, state RUN;
  - stall_cnt=3 with HAZARD_PERF_CNT_EN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_err rises after cycle 5 edge and stays 1 with all en=0 after dmem_ready=1. rst=0 clears mem_err asynchronously, without waiting for a clk edge.
- Wait plus branch: branch held in EX during a 2-cycle memstall -> flushes asserted only on the dmem_ready cycle.
